mouse_trackball: RTL and testbench

Converts PS/2 mouse packets from hps_io into the quadrature trackball signals that the centipede core samples on trakball_i.
- X and Y each have a signed motion accumulator.
- The accumulators drain at a fixed step rate, which produces direction and clock bits per axis.
- Sits between hps_io (ps2_mouse) and the centipede core (trakball_i, flip_o), in clk_sys.

---
 rtl/mouse_trackball_pkg.sv | 29 ++
 rtl/mouse_trackball_if.sv | 11 +
 rtl/trackball_axis.sv | 83 ++++++++
 rtl/mouse_trackball.sv | 70 +++++++
 tb/tb_mouse_trackball.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_trackball_pkg.sv
// Shared types, ps2_mouse field positions and saturating arithmetic for mouse_trackball.
package mouse_trackball_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STEP} drain_state_t;

  localparam int unsigned PKT_TOGGLE_BIT = 24;
  localparam int unsigned Y_BYTE_HI      = 23;
  localparam int unsigned Y_BYTE_LO      = 16;
  localparam int unsigned X_BYTE_HI      = 15;
  localparam int unsigned X_BYTE_LO      = 8;
  localparam int unsigned Y_SIGN_BIT     = 5;
  localparam int unsigned X_SIGN_BIT     = 4;
  localparam int unsigned BTN_BIT        = 0;

  // acc + d - step, clamped symmetrically so the most negative code never appears
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [31:0] d,
                                                 input logic signed [31:0] step,
                                                 input int unsigned        w);
    logic signed [31:0] lim;
    logic signed [31:0] sum;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    sum = acc + d - step;
    if (sum > lim)  return lim;
    if (sum < -lim) return -lim;
    return sum;
  endfunction

endpackage

// File: rtl/mouse_trackball_if.sv
// Bus between hps_io/core glue (master) and mouse_trackball (slave).
interface mouse_trackball_if;
  logic [24:0] ps2_mouse;
  logic        flip;
  logic [7:0]  trakball_o;
  logic        fire_o;
  logic        busy_o;

  modport master (output ps2_mouse, flip, input trakball_o, fire_o, busy_o);
  modport slave  (input ps2_mouse, flip, output trakball_o, fire_o, busy_o);
endinterface

// File: rtl/trackball_axis.sv
// One trackball axis: signed motion accumulator drained into dir/clk quadrature bits.
// MOUSE_TRACKBALL_ACCEL_EN doubles deltas whose magnitude exceeds ACCEL_THR.
module trackball_axis
  import mouse_trackball_pkg::*;
#(
  parameter int ACC_W     = 12,
  parameter int ACCEL_THR = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       pkt,
  input  logic       flip,
  input  logic       sign_bit,
  input  logic [7:0] mag,
  output logic       dir,
  output logic       clk_q,
  output logic       nonzero
);

  drain_state_t             state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  d_raw;
  logic signed [ACC_W-1:0]  d_flip;
  logic signed [ACC_W-1:0]  d;
  logic                     acc_pos;
  logic                     do_step;
  int                       step_i;
  logic signed [31:0]       sum;

  always_comb begin
    d_raw  = {{(ACC_W-9){sign_bit}}, sign_bit, mag};
    d_flip = flip ? -d_raw : d_raw;
`ifdef MOUSE_TRACKBALL_ACCEL_EN
    d = (int'(d_flip) > ACCEL_THR || int'(d_flip) < -ACCEL_THR) ? (d_flip <<< 1) : d_flip;
`else
    d = d_flip;
`endif
  end

  // A packet can land between the IDLE decision and the STEP tick; only step
  // when acc still points the way dir was set, otherwise fall back to IDLE.
  always_comb begin
    nonzero = (acc != '0);
    acc_pos = nonzero && !acc[ACC_W-1];
    do_step = tick && (state == STEP) && nonzero && (acc_pos == dir);
    step_i  = 0;
    if (do_step) step_i = dir ? 1 : -1;
    sum = sat_add(int'(acc), pkt ? int'(d) : 0, step_i, ACC_W);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      state <= IDLE;
      dir   <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      acc <= sum[ACC_W-1:0];
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (nonzero) begin
              if (acc_pos != dir) begin
                dir   <= acc_pos;
                state <= SETUP;
              end else begin
                state <= STEP;
              end
            end
          end
          SETUP: state <= STEP;
          STEP: begin
            if (do_step) clk_q <= ~clk_q;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/mouse_trackball.sv
// PS/2 mouse packets to centipede quadrature trackball bits, in clk_sys.
// Optional MOUSE_TRACKBALL_ACCEL_EN enables delta doubling above ACCEL_THR.
module mouse_trackball
  import mouse_trackball_pkg::*;
#(
  parameter int ACC_W     = 12,
  parameter int STEP_DIV  = 4,
  parameter int ACCEL_THR = 16
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  mouse_trackball_if.slave bus
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          toggle_q;
  logic          pkt;
  logic          dirx, clkx, nzx;
  logic          diry, clky, nzy;

  assign tick = (presc == PW'(STEP_DIV - 1));
  assign pkt  = bus.ps2_mouse[PKT_TOGGLE_BIT] ^ toggle_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      toggle_q   <= 1'b0;
      bus.fire_o <= 1'b1;
      bus.busy_o <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      toggle_q   <= bus.ps2_mouse[PKT_TOGGLE_BIT];
      bus.fire_o <= ~bus.ps2_mouse[BTN_BIT];
      bus.busy_o <= nzx | nzy;
    end
  end

  trackball_axis #(.ACC_W(ACC_W), .ACCEL_THR(ACCEL_THR)) u_axis_x (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (tick),
    .pkt     (pkt),
    .flip    (bus.flip),
    .sign_bit(bus.ps2_mouse[X_SIGN_BIT]),
    .mag     (bus.ps2_mouse[X_BYTE_HI:X_BYTE_LO]),
    .dir     (dirx),
    .clk_q   (clkx),
    .nonzero (nzx)
  );

  trackball_axis #(.ACC_W(ACC_W), .ACCEL_THR(ACCEL_THR)) u_axis_y (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (tick),
    .pkt     (pkt),
    .flip    (bus.flip),
    .sign_bit(bus.ps2_mouse[Y_SIGN_BIT]),
    .mag     (bus.ps2_mouse[Y_BYTE_HI:Y_BYTE_LO]),
    .dir     (diry),
    .clk_q   (clky),
    .nonzero (nzy)
  );

  // dir/clk are flops inside the axes, so the packed output is registered
  assign bus.trakball_o = {dirx, dirx, clkx, clkx, diry, diry, clky, clky};

endmodule

// File: tb/tb_mouse_trackball.sv
// Scoreboard bench for mouse_trackball: expected toggle directions queued per packet.
module tb_mouse_trackball;

  localparam int ACC_W     = 12;
  localparam int STEP_DIV  = 4;
  localparam int ACCEL_THR = 16;
  localparam int LIM       = 2047;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  mouse_trackball_if bus();

  mouse_trackball #(.ACC_W(ACC_W), .STEP_DIV(STEP_DIV), .ACCEL_THR(ACCEL_THR)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard state
  bit   qx[$];
  bit   qy[$];
  int   macc_x, macc_y;
  bit   pend;
  int   pend_dx, pend_dy;
  bit   prev_nz;
  logic [7:0] prev_trak;
  int   cyc;
  int   tx_cyc, ty_cyc, dirx_chg, diry_chg;
  int   tog_x = 0, tog_y = 0, tog_x_dir0 = 0, tog_y_dir1 = 0, coincide = 0;

  // driver state
  bit tgl, btn, flp;

  function automatic int model_delta(input int raw, input bit fl);
    int d;
    d = fl ? -raw : raw;
`ifdef MOUSE_TRACKBALL_ACCEL_EN
    if (d > ACCEL_THR || d < -ACCEL_THR) d = d * 2;
`endif
    return d;
  endfunction

  function automatic int msat(input int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic reset_model();
    qx.delete(); qy.delete();
    macc_x = 0; macc_y = 0; pend = 0; prev_nz = 0;
    prev_trak = 8'h00; cyc = 0;
    tx_cyc = -1000; ty_cyc = -1000; dirx_chg = -1000; diry_chg = -1000;
  endtask

  always @(posedge clk_sys) begin
    logic [7:0] t;
    bit tx, ty, e;
    int sx, sy;
    #1;
    if (reset_n) begin
      cyc++;
      t  = bus.trakball_o;
      tx = t[5] != prev_trak[5];
      ty = t[1] != prev_trak[1];
      if (t[7] != prev_trak[7]) dirx_chg = cyc;
      if (t[3] != prev_trak[3]) diry_chg = cyc;
      sx = 0; sy = 0;
      if (tx) begin
        tog_x++;
        if (!t[7]) tog_x_dir0++;
        check("x_dup", {30'd0, t[7] ^ t[6], t[5] ^ t[4]}, 0);
        check("x_toggle_expected", qx.size() > 0, 1);
        check("x_spacing", (cyc - tx_cyc) >= 2 * STEP_DIV, 1);
        check("x_dir_setup", (cyc - dirx_chg) >= STEP_DIV, 1);
        tx_cyc = cyc;
        if (qx.size() > 0) begin
          e = qx.pop_front();
          check("x_dir", t[7], e);
          sx = e ? 1 : -1;
        end
      end
      if (ty) begin
        tog_y++;
        if (t[3]) tog_y_dir1++;
        check("y_dup", {30'd0, t[3] ^ t[2], t[1] ^ t[0]}, 0);
        check("y_toggle_expected", qy.size() > 0, 1);
        check("y_spacing", (cyc - ty_cyc) >= 2 * STEP_DIV, 1);
        check("y_dir_setup", (cyc - diry_chg) >= STEP_DIV, 1);
        ty_cyc = cyc;
        if (qy.size() > 0) begin
          e = qy.pop_front();
          check("y_dir", t[3], e);
          sy = e ? 1 : -1;
        end
      end
      check("busy", bus.busy_o, prev_nz);
      if (pend) begin
        if (tx) coincide++;
        macc_x = msat(macc_x + pend_dx - sx);
        macc_y = msat(macc_y + pend_dy - sy);
        qx.delete(); qy.delete();
        for (int i = 0; i < (macc_x < 0 ? -macc_x : macc_x); i++) qx.push_back(macc_x > 0);
        for (int i = 0; i < (macc_y < 0 ? -macc_y : macc_y); i++) qy.push_back(macc_y > 0);
        pend = 0;
      end else begin
        macc_x -= sx;
        macc_y -= sy;
      end
      prev_nz   = (macc_x != 0) || (macc_y != 0);
      prev_trak = t;
    end
  end

  task automatic send_pkt(input int dx, input int dy);
    logic [8:0] x9, y9;
    @(negedge clk_sys);
    x9 = dx[8:0];
    y9 = dy[8:0];
    tgl = ~tgl;
    bus.ps2_mouse = {tgl, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 3'b000, btn};
    bus.flip = flp;
    pend_dx = model_delta(dx, flp);
    pend_dy = model_delta(dy, flp);
    pend = 1;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk_sys);
    while ((bus.busy_o || qx.size() != 0 || qy.size() != 0) && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_drain_in_time"}, n < limit, 1);
    check({tag, "_busy_low"}, bus.busy_o, 0);
  endtask

  task automatic wait_x_toggle(input int t0, input string tag);
    int n;
    n = 0;
    while (tog_x == t0 && n < 200) begin
      @(posedge clk_sys);
      #2;
      n++;
    end
    check({tag, "_toggle_seen"}, tog_x != t0, 1);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int t0, t0d, c0;
    logic [3:0] y0;

    // 1: reset values, fire latency, asynchronous reset mid-drain
    tgl = 0; btn = 0; flp = 0;
    bus.ps2_mouse = '0;
    bus.flip = 1'b0;
    reset_model();
    #23;
    check("rst_trak", bus.trakball_o, 8'h00);
    check("rst_fire", bus.fire_o, 1);
    check("rst_busy", bus.busy_o, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rel_trak", bus.trakball_o, 8'h00);
    check("rel_fire", bus.fire_o, 1);
    check("rel_busy", bus.busy_o, 0);

    btn = 1;
    bus.ps2_mouse[0] = 1'b1;
    #1 check("fire_not_yet", bus.fire_o, 1);
    @(posedge clk_sys); #2;
    check("fire_low", bus.fire_o, 0);
    @(negedge clk_sys);
    btn = 0;
    bus.ps2_mouse[0] = 1'b0;
    @(posedge clk_sys); #2;
    check("fire_high", bus.fire_o, 1);

    send_pkt(50, 9);
    repeat (40) @(posedge clk_sys);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_trak", bus.trakball_o, 8'h00);
    check("async_rst_fire", bus.fire_o, 1);
    check("async_rst_busy", bus.busy_o, 0);
    tgl = 0;
    bus.ps2_mouse = '0;
    reset_model();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (30) @(negedge clk_sys);
    check("post_rst_trak", bus.trakball_o, 8'h00);
    check("post_rst_busy", bus.busy_o, 0);

    // 2: X=+3 from idle, Y static
    t0 = tog_x;
    y0 = bus.trakball_o[3:0];
    send_pkt(3, 0);
    wait_idle(400, "t2");
    check("t2_x_toggles", tog_x - t0, 3);
    check("t2_dirx", bus.trakball_o[7], 1);
    check("t2_y_static", bus.trakball_o[3:0], y0);

    // 3: reversal mid-drain
    t0 = tog_x; t0d = tog_x_dir0;
    send_pkt(2, 0);
    wait_x_toggle(t0, "t3");
    send_pkt(-5, 0);
    wait_idle(400, "t3");
    check("t3_x_toggles", tog_x - t0, 5);
    check("t3_x_neg_toggles", tog_x_dir0 - t0d, 4);
    check("t3_dirx", bus.trakball_o[7], 0);

    // 4: packet lands on the STEP tick with acc=+1
    t0 = tog_x; c0 = coincide;
    send_pkt(2, 0);
    wait_x_toggle(t0, "t4");
    repeat (7) @(negedge clk_sys);
    send_pkt(1, 0);
    wait_idle(400, "t4");
    check("t4_coincide", coincide - c0, 1);
    check("t4_x_toggles", tog_x - t0, 3);

    // 5: flip negates Y; X saturation without wrap
    flp = 1;
    t0 = tog_y; t0d = tog_y_dir1;
    send_pkt(0, 7);
    wait_idle(400, "t5y");
    check("t5_y_toggles", tog_y - t0, 7);
    check("t5_y_pos_toggles", tog_y_dir1 - t0d, 0);
    check("t5_diry", bus.trakball_o[3], 0);
    flp = 0;
    t0 = tog_x; t0d = tog_x_dir0;
    for (int i = 0; i < 20; i++) send_pkt(255, 0);
    wait_idle(20000, "t5x");
    check("t5_x_sat_min_toggles", (tog_x - t0) >= LIM, 1);
    check("t5_x_sat_max_toggles", (tog_x - t0) <= LIM + 20, 1);
    check("t5_x_no_wrap", tog_x_dir0 - t0d, 0);

    // 6: delta above the acceleration threshold
    t0 = tog_x;
    send_pkt(20, 0);
    wait_idle(1000, "t6");
`ifdef MOUSE_TRACKBALL_ACCEL_EN
    check("t6_x_toggles", tog_x - t0, 40);
`else
    check("t6_x_toggles", tog_x - t0, 20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
